// File: rtl/spw_pkg.sv
// spw_pkg: SpaceWire control codes, character lengths and helpers for building characters.
package spw_pkg;
  localparam int CREDIT_MAX = 56;
  localparam logic [1:0] CODE_FCT = 2'b00;
  localparam logic [1:0] CODE_EOP = 2'b10;
  localparam logic [1:0] CODE_EEP = 2'b01;
  localparam logic [1:0] CODE_ESC = 2'b11;
  localparam logic [3:0] LEN_CTRL = 4'd4;
  localparam logic [3:0] LEN_DATA = 4'd10;
  localparam logic [3:0] LEN_NULL = 4'd8;
  localparam logic [3:0] LEN_TIME = 4'd14;
  typedef enum logic [1:0] {C_NULL, C_FCT, C_NCHAR, C_TIME} char_t;
  // Characters are packed with the first wire bit (P) in bit 0.
  function automatic logic [3:0] ctrl_char(input logic [1:0] code, input logic p);
    return {code[1], code[0], 1'b1, p};
  endfunction
  function automatic logic [9:0] data_char(input logic [7:0] d, input logic p);
    return {d, 1'b0, p};
  endfunction
endpackage

// File: rtl/spw_ds_encoder.sv
// spw_ds_encoder: Data-Strobe encoder; exactly one of dout/sout toggles per bit_tick.
module spw_ds_encoder (
  input  logic clk,
  input  logic rst,
  input  logic bit_tick,
  input  logic bit_in,
  output logic dout,
  output logic sout
);
  logic dout_q, dout_d, sout_q, sout_d;
  always_comb begin
    dout_d = bit_tick ? bit_in : dout_q;
    sout_d = bit_tick ? sout_q ^ ~(bit_in ^ dout_q) : sout_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= 1'b0;
      sout_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      sout_q <= sout_d;
    end
  end
  assign dout = dout_q;
  assign sout = sout_q;
endmodule

// File: rtl/tx_spw.sv
// tx_spw: SpaceWire character transmitter with DS encoding and FCT credit tracking.
// Define SPW_TX_TIMECODE_EN to enable the Time-Code path.
module tx_spw #(
  parameter int DIV_W      = 7,
  parameter int CREDIT_MAX = spw_pkg::CREDIT_MAX
) (
  input  logic             tx_clk,
  input  logic             tx_reset,
  input  logic             tx_enable,
  input  logic             tx_send_fct,
  input  logic             tx_send_data,
  input  logic [DIV_W-1:0] tx_clk_div,
  input  logic             tx_fct_req,
  output logic             tx_fct_ack,
  input  logic             rx_got_fct,
  input  logic [8:0]       tx_data_flag,
  input  logic             tx_data_valid,
  output logic             tx_data_ready,
  input  logic             tick_in,
  input  logic [7:0]       time_in,
  output logic             tx_dout,
  output logic             tx_sout,
  output logic [5:0]       tx_credit,
  output logic             tx_credit_error
);
  import spw_pkg::*;
  logic rst;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0] left_q, left_d, len;
  logic [13:0] sh_q, sh_d, chr;
  logic par_q, par_d, par_nxt;
  logic [5:0] credit_q, credit_d;
  logic err_q, err_d;
  logic [6:0] credit_sum;
  logic bit_tick, load, tx_bit, nctrl, tick_v;
  logic [7:0] time_v;
  char_t sel;
  assign rst = tx_reset | ~tx_enable;
`ifdef SPW_TX_TIMECODE_EN
  logic tick_q, tick_d;
  logic [7:0] time_q, time_d;
  always_comb begin
    tick_d = tick_in && tx_send_data ? 1'b1 : load && sel == C_TIME ? 1'b0 : tick_q;
    time_d = tick_in && tx_send_data ? time_in : time_q;
  end
  always_ff @(posedge tx_clk) begin
    if (rst) begin
      tick_q <= 1'b0;
      time_q <= 8'd0;
    end else begin
      tick_q <= tick_d;
      time_q <= time_d;
    end
  end
  assign tick_v = tick_q;
  assign time_v = time_q;
`else
  logic unused_time;
  assign unused_time = ^{tick_in, time_in};
  assign tick_v = 1'b0;
  assign time_v = 8'd0;
`endif
  always_comb begin
    bit_tick = !rst && div_q == '0;
    div_d = bit_tick ? tx_clk_div : div_q - 1'b1;
    load = bit_tick && left_q == 4'd0;
    sel = tx_send_data && tick_v ? C_TIME
        : tx_send_fct && tx_fct_req ? C_FCT
        : tx_send_data && tx_data_valid && credit_q != 6'd0 ? C_NCHAR
        : C_NULL;
    nctrl = tx_data_flag[8];
    // Control chars take P = previous parity, data chars its complement.
    chr = sel == C_TIME ? {data_char(time_v, 1'b1), ctrl_char(CODE_ESC, par_q)}
        : sel == C_FCT ? {10'd0, ctrl_char(CODE_FCT, par_q)}
        : sel == C_NCHAR ? (nctrl ? {10'd0, ctrl_char({~tx_data_flag[0], tx_data_flag[0]}, par_q)}
                                  : {4'd0, data_char(tx_data_flag[7:0], ~par_q)})
        : {6'd0, ctrl_char(CODE_FCT, 1'b0), ctrl_char(CODE_ESC, par_q)};
    len = sel == C_TIME ? LEN_TIME
        : sel == C_FCT ? LEN_CTRL
        : sel == C_NCHAR ? (nctrl ? LEN_CTRL : LEN_DATA)
        : LEN_NULL;
    par_nxt = sel == C_TIME ? ^time_v
            : sel == C_NCHAR ? (nctrl ? 1'b1 : ^tx_data_flag[7:0])
            : 1'b0;
    tx_bit = load ? chr[0] : sh_q[0];
    sh_d = !bit_tick ? sh_q : load ? chr >> 1 : sh_q >> 1;
    left_d = !bit_tick ? left_q : load ? len - 4'd1 : left_q - 4'd1;
    par_d = load ? par_nxt : par_q;
    tx_data_ready = load && sel == C_NCHAR;
    tx_fct_ack = load && sel == C_FCT;
    credit_sum = {1'b0, credit_q} + (rx_got_fct ? 7'd8 : 7'd0) - {6'd0, tx_data_ready};
    credit_d = credit_sum > 7'(CREDIT_MAX) ? credit_q : credit_sum[5:0];
    err_d = err_q | (credit_sum > 7'(CREDIT_MAX));
  end
  always_ff @(posedge tx_clk) begin
    if (rst) begin
      div_q    <= '0;
      left_q   <= 4'd0;
      sh_q     <= 14'd0;
      par_q    <= 1'b0;
      credit_q <= 6'd0;
      err_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      left_q   <= left_d;
      sh_q     <= sh_d;
      par_q    <= par_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end
  spw_ds_encoder u_ds (
    .clk(tx_clk),
    .rst(rst),
    .bit_tick(bit_tick),
    .bit_in(tx_bit),
    .dout(tx_dout),
    .sout(tx_sout)
  );
  assign tx_credit = credit_q;
  assign tx_credit_error = err_q;
endmodule
